// File: rtl/game_sequencer.sv
// Game-flow controller for the flappy-bird datapath: IDLE/PLAY/DYING/OVER sequencing,
// restart/flap strobes, score, high score and pipe-speed level.
module game_sequencer #(
    parameter int unsigned DEATH_FRAMES     = 30,
    parameter int unsigned POINTS_PER_LEVEL = 5,
    parameter int unsigned SPEED_INIT       = 2,
    parameter int unsigned SPEED_MAX        = 6,
    parameter int unsigned SCORE_MAX        = 999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        flap,
    input  logic        collision,
    input  logic [10:0] bird_x,
    input  logic [10:0] pipe1_x,
    input  logic [10:0] pipe2_x,
    output logic [1:0]  state,
    output logic        run,
    output logic        flap_pulse,
    output logic        restart,
    output logic [9:0]  score,
    output logic [9:0]  high_score,
    output logic [2:0]  speed
);

    localparam int unsigned SCORE_W = 10;
    localparam int unsigned SPEED_W = 3;
    localparam int unsigned FRAME_W = $clog2(DEATH_FRAMES + 1);
    localparam int unsigned LEVEL_W = $clog2(POINTS_PER_LEVEL + 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 run_q, run_d;
    logic                 flap_pulse_q, flap_pulse_d;
    logic                 restart_q, restart_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   high_q, high_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 flap_q;
    logic                 pass1_q, pass1_d;
    logic                 pass2_q, pass2_d;

    logic                 flap_rise;
    logic                 pass1_now, pass2_now;
    logic                 rise1, rise2;
    logic [1:0]           points;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;
    logic [LEVEL_W-1:0]   level_sum;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            run_q        <= 1'b0;
            flap_pulse_q <= 1'b0;
            restart_q    <= 1'b0;
            score_q      <= '0;
            high_q       <= '0;
            speed_q      <= SPEED_W'(SPEED_INIT);
            level_q      <= '0;
            frame_q      <= '0;
            flap_q       <= 1'b0;
            pass1_q      <= 1'b0;
            pass2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            flap_pulse_q <= flap_pulse_d;
            restart_q    <= restart_d;
            score_q      <= score_d;
            high_q       <= high_d;
            speed_q      <= speed_d;
            level_q      <= level_d;
            frame_q      <= frame_d;
            flap_q       <= flap;
            pass1_q      <= pass1_d;
            pass2_q      <= pass2_d;
        end
    end

    // Next-state, scoring and strobe logic
    always_comb begin
        state_d      = state_q;
        flap_pulse_d = 1'b0;
        restart_d    = 1'b0;
        score_d      = score_q;
        high_d       = high_q;
        speed_d      = speed_q;
        level_d      = level_q;
        frame_d      = frame_q;

        flap_rise = flap & ~flap_q;
        pass1_now = (pipe1_x < bird_x);
        pass2_now = (pipe2_x < bird_x);
        pass1_d   = frame_tick ? pass1_now : pass1_q;
        pass2_d   = frame_tick ? pass2_now : pass2_q;
        rise1     = frame_tick & pass1_now & ~pass1_q;
        rise2     = frame_tick & pass2_now & ~pass2_q;
        points    = 2'(rise1) + 2'(rise2);
        score_sum = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(points);
        score_sat = (score_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                          : score_sum[SCORE_W-1:0];
        level_sum = level_q + LEVEL_W'(points);

        case (state_q)
            S_IDLE: begin
                if (flap_rise) begin
                    state_d      = S_PLAY;
                    restart_d    = 1'b1;
                    flap_pulse_d = 1'b1;
                    score_d      = '0;
                    level_d      = '0;
                    frame_d      = '0;
                    speed_d      = SPEED_W'(SPEED_INIT);
                end
            end
            S_PLAY: begin
                score_d = score_sat;
                // A double point crossing the boundary bumps speed once and keeps the remainder
                if (level_sum >= LEVEL_W'(POINTS_PER_LEVEL)) begin
                    level_d = level_sum - LEVEL_W'(POINTS_PER_LEVEL);
                    if (speed_q < SPEED_W'(SPEED_MAX)) begin
                        speed_d = speed_q + SPEED_W'(1);
                    end
                end else begin
                    level_d = level_sum;
                end
                if (collision) begin
                    state_d = S_DYING;
                end else if (flap_rise) begin
                    flap_pulse_d = 1'b1;
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (frame_q == FRAME_W'(DEATH_FRAMES - 1)) begin
                        frame_d = '0;
                        state_d = S_OVER;
                        if (score_q > high_q) begin
                            high_d = score_q;
                        end
                    end else begin
                        frame_d = frame_q + FRAME_W'(1);
                    end
                end
            end
            S_OVER: begin
                if (flap_rise) begin
                    state_d   = S_IDLE;
                    restart_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        run_d = (state_d == S_PLAY);
    end

    assign state      = state_q;
    assign run        = run_q;
    assign flap_pulse = flap_pulse_q;
    assign restart    = restart_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign speed      = speed_q;

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game-flow controller for the flappy-bird datapath. It sequences IDLE/PLAY/DYING/OVER states and gates bird physics and pipe motion via `run`. It issues the one-cycle `restart` strobe to the collision detector and bird/pipe generators. It also keeps score, high score and the difficulty (pipe speed) level. It consumes the registered `collision` flag, the bird/pipe X coordinates and the player's flap button.

Parameters:
DEATH_FRAMES, 30, frames spent frozen in DYING before OVER
POINTS_PER_LEVEL, 5, points per speed increment
SPEED_INIT, 2, pipe speed (px/frame) after restart
SPEED_MAX, 6, speed saturation value
SCORE_MAX, 999, score and high-score saturation value

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; returns block to IDLE
frame_tick  input  1  one-cycle pulse per video frame
flap  input  1  raw button level, already synchronised to clk
collision  input  1  level from collision detector, high while dead
bird_x  input  11  bird X position
pipe1_x  input  11  pipe 1 right edge X
pipe2_x  input  11  pipe 2 right edge X
state  output  2  0=IDLE, 1=PLAY, 2=DYING, 3=OVER
run  output  1  high only in PLAY; enables physics and pipe motion
flap_pulse  output  1  one-cycle flap impulse to bird physics
restart  output  1  one-cycle strobe that clears collision detector, bird and pipes
score  output  10  current score, binary
high_score  output  10  best score since reset
speed  output  3  pipe speed for the pipe generator

Behaviour:
- Async reset:
  - state=IDLE, run=0, flap_pulse=0, restart=0.
  - score=0, high_score=0, speed=SPEED_INIT.
  - Frame counter=0, level counter=0, flap edge register=0, pass flags=0.
- Flap edge: flap_rise = flap & ~flap_q, where flap_q is registered every clk. Holding the button yields exactly one rise.
- IDLE:
  - flap_rise -> PLAY on the next edge.
  - Same cycle (registered, so visible 1 cycle after the rise): restart=1 and flap_pulse=1.
  - score, level counter and frame counter cleared; speed=SPEED_INIT.
  - collision ignored in IDLE.
- PLAY:
  - run=1.
  - flap_rise -> flap_pulse=1 for one cycle, unless collision=1 in the same cycle; collision wins and no pulse is issued.
  - collision=1 -> DYING; run drops the cycle after collision is sampled high.
- Scoring (PLAY only, evaluated on frame_tick):
  - passN = (pipeN_x < bird_x), registered on each frame_tick.
  - A point is earned on each 0->1 transition of passN.
  - Both pipes transitioning on the same tick add 2.
  - Pipe respawn (pipe_x jumps large) clears passN without scoring.
  - score saturates at SCORE_MAX; surplus points are discarded.
- Speed:
  - Each earned point increments the level counter.
  - When the level counter reaches POINTS_PER_LEVEL it wraps to 0 and speed increments, saturating at SPEED_MAX.
  - A +2 tick that crosses the boundary increments speed once and leaves the remainder in the counter.
- DYING:
  - run=0; frame counter increments on frame_tick.
  - At DEATH_FRAMES ticks -> OVER.
  - flap ignored, and flap_rise is not remembered.
- OVER:
  - On entry (one cycle), high_score <= score if score > high_score.
  - flap_rise -> IDLE with restart=1 for one cycle. score is kept, so it remains displayed, until IDLE->PLAY.
- collision still high in IDLE after restart has no effect, because the detector clears on restart.
- frame_tick and flap_rise in the same cycle are both honoured.
- Reset mid-game aborts immediately and loses high_score.
- restart and flap_pulse are never high for more than one consecutive cycle.

Test Plan:
- Reset, then IDLE, then flap held high 10 cycles -> exactly one restart pulse and one flap_pulse, both 1 cycle after the rise; state=PLAY; run=1; speed=2.
- PLAY, bird_x=100, pipe1_x stepping 105->95 over ticks -> score 0->1 once. Respawn to pipe1_x=700 then a second pass -> score=2.
- PLAY, pipe1_x and pipe2_x both cross bird_x on the same tick (POINTS_PER_LEVEL=5, score=4) -> score=6, speed=3, level counter=1.
- PLAY, collision=1 and flap_rise in the same cycle -> no flap_pulse; state=DYING; run=0. After 30 frame_ticks -> OVER; high_score=score.
- OVER with score=7, high_score=9 -> high_score stays 9. flap -> IDLE with one restart pulse; score still 7 until the next flap, then 0.
- Force score=998, two points earned -> score=999 and stays there. Speed saturates at 6 after further levels. Async reset asserted mid-PLAY -> all outputs return to their reset values immediately.
